// File: rtl/song_sequencer.sv
// song_sequencer: writable song memory of (note, duration) entries played
// back in lesson mode (LED hint, wait for the right key) or autoplay mode
// (beat-timed, optional loop). When no song is running it encodes the
// lowest pressed key as a note code.
module song_sequencer #(
    parameter int NUM_KEYS = 8,
    parameter int NOTE_W   = 4,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int DUR_W    = 4,
    parameter int BEAT_DIV = 12500000
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [1:0]          mode,
    input  logic                start,
    input  logic                loop,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [NOTE_W-1:0]   wr_note,
    input  logic [DUR_W-1:0]    wr_dur,
    input  logic [ADDR_W:0]     len,
    output logic [NOTE_W-1:0]   note,
    output logic [NUM_KEYS-1:0] Led,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   pos,
    output logic [7:0]          mistakes,
    output logic                beat
);
    localparam int CNT_W   = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int ENTRY_W = NOTE_W + DUR_W;

    localparam logic [1:0] MODE_LESSON = 2'b01;
    localparam logic [1:0] MODE_AUTO   = 2'b10;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_L_WAIT = 3'd2;
    localparam logic [2:0] S_L_HOLD = 3'd3;
    localparam logic [2:0] S_A_PLAY = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [ADDR_W:0]  LEN_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_DIV - 1);

    logic [2:0]          state, state_nxt;
    logic [ADDR_W-1:0]   pos_nxt;
    logic [1:0]          run_mode, run_mode_nxt;
    logic [NOTE_W-1:0]   cur_note, cur_note_nxt;
    logic [DUR_W-1:0]    ticks, ticks_nxt;
    logic [7:0]          mistakes_nxt;
    logic [CNT_W-1:0]    beat_cnt;
    logic [NUM_KEYS-1:0] keys_q;
    logic [NOTE_W-1:0]   free_note, free_q;
    logic [NUM_KEYS-1:0] cur_hot;

    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [ENTRY_W-1:0]  rd_q;
    logic [NOTE_W-1:0]   rd_note;
    logic [DUR_W-1:0]    rd_dur;

    logic start_ok;
    logic running;
    logic is_last;
    logic wrong_press;

    assign rd_note = rd_q[ENTRY_W-1:DUR_W];
    assign rd_dur  = rd_q[DUR_W-1:0];

    assign start_ok = start && (mode == MODE_LESSON || mode == MODE_AUTO) && (len != '0);
    assign running  = (state != S_IDLE) && (state != S_FINISH);
    // Lowering len below pos+1 mid-song makes the current entry the last one.
    assign is_last  = ({1'b0, pos} + LEN_ONE) >= len;
    // A wrong press is a fresh press (keys were all released) that is not the hint.
    assign wrong_press = (keys_q == '0) && (keys != '0) && (keys != cur_hot);

    assign beat     = (beat_cnt == CNT_LAST);
    assign busy     = running;
    assign done     = (state == S_FINISH);

    // Lowest-indexed pressed key wins; code 0 means no key.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
        free_note = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (keys[k]) free_note = NOTE_W'(k + 1);
        end
    end

    // One-hot LED pattern of the current entry's note; a rest lights nothing.
    always_comb begin
        cur_hot = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (cur_note == NOTE_W'(k + 1)) cur_hot[k] = 1'b1;
        end
    end

    // Song memory: synchronous write, registered read of the entry pos is moving to.
    always_ff @(posedge CLK) begin
        // NOTE: the song memory is deliberately not reset; its contents are don't-care until written.
        if (wr_en) mem[wr_addr] <= {wr_note, wr_dur};
        rd_q <= mem[pos_nxt];
    end

    // Beat divider plus the key history used for free play and press detection.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            beat_cnt <= '0;
            keys_q   <= '0;
            free_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            if (start_ok || beat) beat_cnt <= '0;
            else                  beat_cnt <= beat_cnt + CNT_W'(1);
            keys_q <= keys;
            free_q <= free_note;
        end
    end

    // Next-state logic: start and abort override the per-state behaviour.
    always_comb begin
        state_nxt    = state;
        pos_nxt      = pos;
        run_mode_nxt = run_mode;
        cur_note_nxt = cur_note;
        ticks_nxt    = ticks;
        mistakes_nxt = mistakes;
        if (start_ok) begin
            state_nxt    = S_FETCH;
            pos_nxt      = '0;
            run_mode_nxt = mode;
            cur_note_nxt = '0;
            if (mode == MODE_LESSON) mistakes_nxt = '0;
        end else if (running && mode != run_mode) begin
            state_nxt = S_IDLE;
            pos_nxt   = '0;
        end else begin
            case (state)
                S_FETCH: begin
                    cur_note_nxt = rd_note;
                    if (run_mode == MODE_AUTO) begin
                        ticks_nxt = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
                        state_nxt = S_A_PLAY;
                    end else if (rd_note == '0) begin
                        if (is_last) begin
                            state_nxt = S_FINISH;
                            pos_nxt   = '0;
                        end else begin
                            pos_nxt = pos + ADDR_W'(1);
                        end
                    end else begin
                        state_nxt = S_L_WAIT;
                    end
                end
                S_L_WAIT: begin
                    if (keys == cur_hot) state_nxt = S_L_HOLD;
                    else if (wrong_press && mistakes != 8'hFF) mistakes_nxt = mistakes + 8'd1;
                end
                S_L_HOLD: begin
                    if (keys == '0) begin
                        if (is_last) begin
                            state_nxt = S_FINISH;
                            pos_nxt   = '0;
                        end else begin
                            state_nxt = S_FETCH;
                            pos_nxt   = pos + ADDR_W'(1);
                        end
                    end
                end
                S_A_PLAY: begin
                    if (beat) begin
                        if (ticks <= DUR_W'(1)) begin
                            if (!is_last) begin
                                state_nxt = S_FETCH;
                                pos_nxt   = pos + ADDR_W'(1);
                            end else if (loop) begin
                                state_nxt = S_FETCH;
                                pos_nxt   = '0;
                            end else begin
                                state_nxt = S_FINISH;
                                pos_nxt   = '0;
                            end
                        end else begin
                            ticks_nxt = ticks - DUR_W'(1);
                        end
                    end
                end
                S_FINISH: state_nxt = S_IDLE;
                S_IDLE:   state_nxt = S_IDLE;
                default: begin
                    state_nxt = S_IDLE;
                    pos_nxt   = '0;
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            pos      <= '0;
            run_mode <= '0;
            cur_note <= '0;
            ticks    <= '0;
            mistakes <= '0;
        end else begin
            state    <= state_nxt;
            pos      <= pos_nxt;
            run_mode <= run_mode_nxt;
            cur_note <= cur_note_nxt;
            ticks    <= ticks_nxt;
            mistakes <= mistakes_nxt;
        end
    end

    // Output mux: free-play note unless autoplay owns the note; LEDs only while playing.
    always_comb begin
        note = free_q;
        Led  = '0;
        case (state)
            S_L_WAIT, S_L_HOLD: Led = cur_hot;
            S_A_PLAY: begin
                note = cur_note;
                Led  = cur_hot;
            end
            S_FETCH: begin
                if (run_mode == MODE_AUTO) note = cur_note;
            end
            default: begin
                note = free_q;
                Led  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer with a short beat (BEAT_DIV=4).
module tb_song_sequencer;
    localparam int BD = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [1:0] mode;
    logic       start;
    logic       loop;
    logic [7:0] keys;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [3:0] wr_note;
    logic [3:0] wr_dur;
    logic [5:0] len;
    logic [3:0] note;
    logic [7:0] Led;
    logic       busy;
    logic       done;
    logic [4:0] pos;
    logic [7:0] mistakes;
    logic       beat;

    song_sequencer #(.BEAT_DIV(BD)) dut (
        .CLK(CLK), .RESET(RESET), .mode(mode), .start(start), .loop(loop),
        .keys(keys), .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note),
        .wr_dur(wr_dur), .len(len), .note(note), .Led(Led), .busy(busy),
        .done(done), .pos(pos), .mistakes(mistakes), .beat(beat)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int         m_cnt;
    logic [7:0] m_keys_prev;
    int         done_cnt = 0;
    int         log_q[$];
    bit         auto_run = 1'b0;

    // Autoplay song held by the bench
    int s_note[3] = '{5, 3, 1};
    int s_dur[3]  = '{2, 1, 1};
    int exp_list[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int free_of(input logic [7:0] k);
        for (int i = 0; i < 8; i++) if (k[i]) return i + 1;
        return 0;
    endfunction

    function automatic int get_log(input int i);
        if (i < log_q.size()) return log_q[i];
        return -1;
    endfunction

    // Model: free-running beat counter restarted by accepted starts; key history.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_cnt       <= 0;
            m_keys_prev <= '0;
        end else begin
            m_keys_prev <= keys;
            if (start && (mode == 2'b01 || mode == 2'b10) && len != 0) m_cnt <= 0;
            else m_cnt <= (m_cnt + 1) % BD;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge CLK) begin
        if (!RESET) begin
            check("beat", int'(beat), int'(m_cnt == BD - 1));
            check("led_onehot0", int'($onehot0(Led)), 1);
            if (!busy && !done) begin
                check("idle_note", int'(note), free_of(m_keys_prev));
                check("idle_led", int'(Led), 0);
                check("idle_pos", int'(pos), 0);
            end
            if (busy && auto_run && beat) log_q.push_back(int'(pos) * 16 + int'(note));
            if (done) done_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic write_entry(input int a, input int n, input int d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_note = 4'(n);
        wr_dur  = 4'(d);
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        keys = k;
        step(1);
        keys = '0;
        step(1);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            if (done) seen = 1'b1;
        end
        check("wait_done_in_budget", int'(seen), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_note"}, int'(note), 0);
        check({tag, "_led"}, int'(Led), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pos"}, int'(pos), 0);
        check({tag, "_mistakes"}, int'(mistakes), 0);
        check({tag, "_beat"}, int'(beat), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int lit[4];
        RESET = 1'b1; mode = 2'b00; start = 1'b0; loop = 1'b0; keys = '0;
        wr_en = 1'b0; wr_addr = '0; wr_note = '0; wr_dur = '0; len = '0;
        step(2);
        check_all_zero("reset");
        RESET = 1'b0;
        step(1);

        // Free play
        keys = 8'b0010_0100; step(1);
        check("free_note_3", int'(note), 3);
        check("free_led_0", int'(Led), 0);
        keys = 8'b1000_0000; step(1);
        check("free_note_8", int'(note), 8);
        keys = '0; step(1);
        check("free_note_0", int'(note), 0);

        // Ignored starts
        mode = 2'b10; len = 6'd0; pulse_start();
        check("len0_busy", int'(busy), 0);
        step(1);
        check("len0_busy_later", int'(busy), 0);
        mode = 2'b11; len = 6'd3; pulse_start();
        check("mode11_busy", int'(busy), 0);
        mode = 2'b00; pulse_start();
        check("mode00_busy", int'(busy), 0);

        // Lesson
        write_entry(0, 2, 1);
        write_entry(1, 0, 1);
        write_entry(2, 4, 1);
        len = 6'd3; mode = 2'b01;
        pulse_start();
        check("lesson_busy", int'(busy), 1);
        step(1);
        check("lesson_led0", int'(Led), 8'b0000_0010);
        check("lesson_pos0", int'(pos), 0);
        keys = 8'b0000_0010; step(1);
        check("lesson_hold_led", int'(Led), 8'b0000_0010);
        keys = '0; step(3);
        check("lesson_led2", int'(Led), 8'b0000_1000);
        check("lesson_pos2", int'(pos), 2);
        press(8'b0000_0001);
        check("lesson_mistake1", int'(mistakes), 1);
        for (int i = 0; i < 299; i++) press(8'b0000_0001);
        check("lesson_mistake_sat", int'(mistakes), 255);
        check("lesson_still_pos2", int'(pos), 2);
        pulse_start();
        check("restart_pos", int'(pos), 0);
        check("restart_mistakes", int'(mistakes), 0);
        check("restart_busy", int'(busy), 1);
        step(1);
        check("restart_led0", int'(Led), 8'b0000_0010);
        press(8'b0000_0001);
        check("restart_mistake1", int'(mistakes), 1);
        d0 = done_cnt;
        keys = 8'b0000_0010; step(1);
        keys = '0; step(3);
        check("restart_led2", int'(Led), 8'b0000_1000);
        keys = 8'b0000_1000; step(1);
        keys = '0; step(1);
        check("lesson_done", int'(done), 1);
        check("lesson_done_busy", int'(busy), 0);
        check("lesson_done_pos", int'(pos), 0);
        step(2);
        check("lesson_done_once", done_cnt - d0, 1);

        // Autoplay, no loop
        for (int i = 0; i < 3; i++) write_entry(i, s_note[i], s_dur[i]);
        exp_list.delete();
        for (int i = 0; i < 3; i++)
            for (int b = 0; b < (s_dur[i] == 0 ? 1 : s_dur[i]); b++)
                exp_list.push_back(i * 16 + s_note[i]);
        lit = '{5, 5, 16 + 3, 32 + 1};
        mode = 2'b10; loop = 1'b0; log_q.delete(); auto_run = 1'b1;
        d0 = done_cnt;
        pulse_start();
        wait_done(200);
        check("auto_done_busy", int'(busy), 0);
        check("auto_done_pos", int'(pos), 0);
        step(2);
        check("auto_done_once", done_cnt - d0, 1);
        check("auto_beats", log_q.size(), exp_list.size());
        for (int i = 0; i < 4; i++) begin
            check("auto_beat_model", get_log(i), exp_list[i]);
            check("auto_beat_literal", get_log(i), lit[i]);
        end

        // Autoplay with loop, then abort by mode change
        log_q.delete(); loop = 1'b1; d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 300 && log_q.size() < 6; i++) step(1);
        check("loop_beats_reached", int'(log_q.size() >= 6), 1);
        check("loop_busy", int'(busy), 1);
        for (int i = 0; i < 6; i++) check("loop_beat", get_log(i), exp_list[i % 4]);
        check("loop_wrap_literal", get_log(4), 5);
        mode = 2'b00; step(1);
        check("abort_busy", int'(busy), 0);
        check("abort_pos", int'(pos), 0);
        check("abort_done", int'(done), 0);
        step(2);
        check("abort_no_done", done_cnt - d0, 0);
        loop = 1'b0;

        // Reset in the middle of autoplay
        mode = 2'b10;
        pulse_start();
        step(5);
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_note", int'(note), 5);
        check("pre_reset_mistakes", int'(mistakes), 1);
        RESET = 1'b1; #1;
        check_all_zero("midreset");
        auto_run = 1'b0;
        step(1);
        RESET = 1'b0;
        step(2);
        check("post_reset_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Parametrised successor to the piano note-selection and mode logic. Holds a writable song memory of (note, duration) entries and runs it in lesson mode (LED hint, waits for the correct key) or autoplay mode (beat-timed playback, optional loop). With no song running it acts as a free-play key encoder. Output `note` drives the existing clock-select and seven-segment path. `Led` drives the board LEDs.

Parameters:
NUM_KEYS, 8, number of playable keys; note code k (1..NUM_KEYS) = key k-1, code 0 = rest
NOTE_W, 4, note code width (must hold NUM_KEYS)
DEPTH, 32, song memory entries
ADDR_W, 5, log2(DEPTH)
DUR_W, 4, duration field width, in beat ticks
BEAT_DIV, 12500000, CLK cycles per beat tick

Ports:
CLK  in  1  system clock
RESET  in  1  reset; asynchronous, active-high
mode  in  2  00 free, 01 lesson, 10 auto, 11 treated as free
start  in  1  one-cycle pulse; begins or restarts the song in the current mode
loop  in  1  auto mode: wrap to entry 0 instead of finishing
keys  in  NUM_KEYS  debounced key levels, bit i = key i
wr_en  in  1  song memory write strobe
wr_addr  in  ADDR_W  write address
wr_note  in  NOTE_W  note code to write
wr_dur  in  DUR_W  duration to write
len  in  ADDR_W+1  song length in entries (0..DEPTH)
note  out  NOTE_W  currently sounding note code
Led  out  NUM_KEYS  one-hot hint/playing LED
busy  out  1  song running
done  out  1  one-cycle pulse at song completion
pos  out  ADDR_W  current song index
mistakes  out  8  lesson wrong-key count, saturates at 255
beat  out  1  one-cycle beat tick

Behaviour:
- Reset (async, RESET=1): all outputs 0; FSM in IDLE; beat counter 0. Song memory contents are undefined after reset and are not cleared.
- Beat counter: counts 0..BEAT_DIV-1, then wraps. `beat`=1 in the wrap cycle. The counter is cleared on an accepted start.
- Free encoding:
  - free_note = 1 + index of the lowest-indexed set bit in keys; 0 if keys==0.
  - In IDLE, `note` = free_note (registered, 1-cycle latency) and `Led` = 0.
- Memory: synchronous write. Read is registered (1 cycle); the FSM absorbs this latency internally. A write to the entry currently playing takes effect only when that entry is next fetched.
- FSM states: IDLE, FETCH, L_WAIT, L_HOLD, A_PLAY, FINISH.
- Start handling:
  - IDLE + start + mode∈{01,10} + len≠0 → FETCH, with pos=0, busy=1, mistakes cleared (lesson mode only).
  - start with len=0 or mode∈{00,11} is ignored.
  - start while busy restarts from pos=0 (same as from IDLE).
- FETCH: one cycle to read the entry.
  - Lesson, entry note 0 (rest) → skip: pos+1, or FINISH if the last entry.
  - Lesson, otherwise → L_WAIT.
  - Auto → A_PLAY, with tick count = dur; dur=0 is treated as 1.
- L_WAIT:
  - Led = one-hot(entry note - 1); `note` = free_note.
  - keys == exactly that one-hot → L_HOLD.
  - keys changes from 0 to any other nonzero value → mistakes+1 (saturating), then stay in L_WAIT.
- L_HOLD: Led held. On keys==0: if pos==len-1 → FINISH, else pos+1 → FETCH.
- A_PLAY:
  - `note` = entry note; Led = one-hot(entry note - 1), or 0 for a rest. keys are ignored.
  - Each beat decrements the tick count. When it reaches 0: if pos<len-1 → pos+1, FETCH; else if loop → pos=0, FETCH; else FINISH.
- FINISH: done=1 for one cycle; busy=0; pos=0; then → IDLE.
- Abort: if `mode` changes while busy → IDLE next cycle, busy=0, pos=0, no done pulse.
- Length change: if `len` is lowered below pos+1 while running, the current entry is treated as the last one.
- Reset mid-song: immediate return to the reset state.

Test Plan:
- Free play: BEAT_DIV=4, IDLE, keys=8'b0010_0100 → note=3 after 1 cycle. keys=0 → note=0. Led=0 throughout.
- Auto: write entries {(5,2),(3,1),(1,1)}, len=3, mode=10, start → note=5 for 2 beats, then 3 for 1, then 1 for 1. Single done pulse after the 4th beat; busy=0; pos=0.
- Auto with loop=1, same song → after entry 2, pos=0 and note=5 again. No done pulse. busy stays 1.
- Lesson: entries {(2,1),(0,1),(4,1)}, mode=01, start → Led=0000_0010. Press key1 then release → rest skipped, Led=0000_1000. Press key0 → mistakes=1. Press key3 then release → done pulse.
- Edge cases: start with len=0 → stays IDLE with busy=0. mode changed 10→00 mid-song → busy=0, pos=0, no done. RESET asserted mid-A_PLAY → all outputs 0 immediately.
- Saturation/restart: 300 wrong presses → mistakes=255. start while busy at pos=2 → pos=0 and mistakes=0.
